// File: rtl/serial_loader_pkg.sv
// Shared types and constants for the serial nibble loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the default word width and the helper that
// sizes the bit counter. Optional feature macro used by the design:
// PARITY_CHECK_EN.
package serial_loader_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encodings are fixed so state values stay stable across builds, even when
  // PAR and ERR are not used.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    LOAD  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // The counter must be able to hold WIDTH itself so that it can saturate there.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_nibble_loader_bit_counter.sv
// Clearable up-counter that saturates at MAX, with a terminal-count flag.
// Latency: count updates on the clock edge; tc_o is combinational on the next count.
// Backpressure: none; it counts only when inc_i is high.
//
// Ports:
//   clk_i, rst_ni : clock and async active-low reset
//   clr_i         : synchronous clear (has priority over inc_i)
//   inc_i         : increment enable
//   tc_o          : high when the count after this edge equals MAX
module bit_counter
  import serial_loader_pkg::*;
#(
  parameter int MAX = DEFAULT_WIDTH,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The flag looks at the next count, so the caller can act on the same edge
  // as the increment that reaches MAX.
  assign tc_o = (cnt_d == CW'(MAX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_nibble_loader.sv
// Deserialises a framed serial stream and loads the word into the enable register.
// Latency: en and the new D appear WIDTH cycles after the start edge, one more with parity, plus one per sin_valid gap.
// Backpressure: none; the FSM holds while sin_valid is low, and start is ignored while a frame is in progress.
//
// Ports:
//   CLK, RST  : clock and async active-low reset
//   start     : frame start request, sampled in IDLE and ERR
//   sin       : serial data bit
//   sin_valid : sin is valid this cycle
//   D         : parallel word; it changes only when a frame completes
//   en        : one-cycle load strobe per good frame
//   busy      : high in SHIFT and PAR
//   err       : sticky parity-failure flag
// Optional feature: define PARITY_CHECK_EN to expect an even-parity bit after each word.
module serial_nibble_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] D,
  output logic             en,
  output logic             busy,
  output logic             err
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d, shifted;
  logic [WIDTH-1:0]   d_q;
  logic               en_q;
  logic               load;
  logic               cnt_clr, cnt_inc, cnt_tc;

  bit_counter #(.MAX(WIDTH)) u_bit_counter (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  // With LSB-first order, shifting in from the top leaves the first bit in D[0]
  // once the word is complete.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shifted = {sin, shift_q[WIDTH-1:1]};
    end else begin
      shifted = {shift_q[WIDTH-2:0], sin};
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shift_d = shifted;
          cnt_inc = 1'b1;
          if (cnt_tc) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d = LOAD;
            load    = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (sin_valid) begin
          if (sin == ^shift_q) begin
            state_d = LOAD;
            load    = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        if (start) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
`endif
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // D and en are registered on the edge that enters LOAD, so both are visible
  // during the LOAD cycle itself.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      en_q    <= load;
      if (load) begin
        d_q <= shift_d;
      end
    end
  end

  assign D    = d_q;
  assign en   = en_q;
  assign busy = (state_q == SHIFT) || (state_q == PAR);

`ifdef PARITY_CHECK_EN
  // ERR is left only through a new start, so the flag is sticky until then.
  assign err = (state_q == ERR);
`else
  assign err = 1'b0;
`endif

endmodule
